// File: rtl/probe_mux_pkg.sv
// rtl/probe_mux_pkg.sv - shared state type and width helpers for probe_mux_scope
package probe_mux_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    LIVE   = 2'd2,
    FROZEN = 2'd3
  } probe_state_e;

  localparam int DEF_NUM_GROUPS = 4;
  localparam int DEF_PROBE_W    = 8;
  localparam int SEL_W          = idx_w(DEF_NUM_GROUPS);
  localparam int TRIG_W         = idx_w(DEF_PROBE_W);

endpackage

// File: rtl/probe_sync.sv
// rtl/probe_sync.sv - multi-stage synchroniser, one chain per bit, async reset to 0
module probe_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din_i;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout_o = sync_q[STAGES-1];

endmodule

// File: rtl/probe_mux_scope.sv
// rtl/probe_mux_scope.sv - debug probe mux for a PMOD header with blanking, freeze and edge counter
// Optional pulse stretcher on header bits: define PROBE_STRETCH_EN.
module probe_mux_scope
  import probe_mux_pkg::*;
#(
  parameter int NUM_GROUPS     = 4,
  parameter int PROBE_W        = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int BLANK_CYCLES   = 4,
  parameter int CNT_W          = 16,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_GROUPS*PROBE_W-1:0]    probes_i,
  input  logic [idx_w(NUM_GROUPS)-1:0]     sel_i,
  input  logic                             enable_i,
  input  logic                             freeze_i,
  input  logic [idx_w(PROBE_W)-1:0]        trig_bit_i,
  input  logic                             cnt_clr_i,
  output logic [PROBE_W-1:0]               pmod_o,
  output logic [idx_w(NUM_GROUPS)-1:0]     sel_active_o,
  output logic                             blanking_o,
  output logic [CNT_W-1:0]                 edge_cnt_o,
  output logic                             edge_cnt_ovf_o
);

  localparam int GSEL_W  = idx_w(NUM_GROUPS);
  localparam int GTRIG_W = idx_w(PROBE_W);
  localparam int BLANK_W = idx_w(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_RELOAD = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

  if (NUM_GROUPS < 2)     begin : g_chk_groups  $error("NUM_GROUPS must be >= 2");     end
  if (SYNC_STAGES < 2)    begin : g_chk_sync    $error("SYNC_STAGES must be >= 2");    end
  if (BLANK_CYCLES < 1)   begin : g_chk_blank   $error("BLANK_CYCLES must be >= 1");   end
  if (STRETCH_CYCLES < 1) begin : g_chk_stretch $error("STRETCH_CYCLES must be >= 1"); end

  probe_state_e              state_q, state_d;
  logic [GSEL_W-1:0]         sel_q, sel_d;
  logic [BLANK_W-1:0]        blank_cnt_q, blank_cnt_d;
  logic [PROBE_W-1:0]        pmod_q, pmod_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      trig_prev_q, trig_prev_d;

  logic [NUM_GROUPS*PROBE_W-1:0] synced;
  logic [PROBE_W-1:0]            group_live;
  logic [PROBE_W-1:0]            header_bits;
  logic                          trig_now;
  logic                          edge_det;

  probe_sync #(
    .WIDTH  (NUM_GROUPS*PROBE_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (probes_i),
    .dout_o (synced)
  );

  // Unused select codes (non power-of-two group counts) leave the group at zero.
  always_comb begin
    group_live = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (sel_q == GSEL_W'(g)) begin
        group_live = synced[g*PROBE_W +: PROBE_W];
      end
    end
  end

  always_comb begin
    trig_now = 1'b0;
    for (int b = 0; b < PROBE_W; b++) begin
      if (trig_bit_i == GTRIG_W'(b)) begin
        trig_now = group_live[b];
      end
    end
  end

`ifdef PROBE_STRETCH_EN
  localparam int STR_W = idx_w(STRETCH_CYCLES);
  localparam logic [STR_W-1:0] STR_RELOAD = STR_W'(STRETCH_CYCLES - 1);

  logic [PROBE_W-1:0][STR_W-1:0] str_cnt_q, str_cnt_d;
  logic [PROBE_W-1:0]            str_prev_q, str_prev_d;

  always_comb begin
    str_cnt_d   = str_cnt_q;
    str_prev_d  = group_live;
    header_bits = group_live;
    for (int b = 0; b < PROBE_W; b++) begin
      header_bits[b] = group_live[b] | (str_cnt_q[b] != '0);
      if (state_q != LIVE) begin
        str_cnt_d[b] = '0;
      end else if (group_live[b] && !str_prev_q[b]) begin
        str_cnt_d[b] = STR_RELOAD;
      end else if (str_cnt_q[b] != '0) begin
        str_cnt_d[b] = str_cnt_q[b] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_cnt_q  <= '0;
      str_prev_q <= '0;
    end else begin
      str_cnt_q  <= str_cnt_d;
      str_prev_q <= str_prev_d;
    end
  end
`else
  assign header_bits = group_live;
`endif

  // Header register follows the next state so the first live value appears as BLANK ends.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blank_cnt_d = blank_cnt_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          sel_d       = sel_i;
          blank_cnt_d = BLANK_RELOAD;
        end
        BLANK: begin
          if (sel_i != sel_q) begin
            sel_d       = sel_i;
            blank_cnt_d = BLANK_RELOAD;
          end else if (blank_cnt_q == '0) begin
            state_d = LIVE;
          end else begin
            blank_cnt_d = blank_cnt_q - 1'b1;
          end
        end
        LIVE: begin
          if (sel_i != sel_q) begin
            state_d     = BLANK;
            sel_d       = sel_i;
            blank_cnt_d = BLANK_RELOAD;
          end else if (freeze_i) begin
            state_d = FROZEN;
          end
        end
        FROZEN: begin
          if (!freeze_i) begin
            if (sel_i != sel_q) begin
              state_d     = BLANK;
              sel_d       = sel_i;
              blank_cnt_d = BLANK_RELOAD;
            end else begin
              state_d = LIVE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    unique case (state_d)
      LIVE:    pmod_d = header_bits;
      FROZEN:  pmod_d = pmod_q;
      default: pmod_d = '0;
    endcase
  end

  // The previous trigger sample tracks in every state so entering LIVE never fakes an edge.
  always_comb begin
    edge_det    = trig_now & ~trig_prev_q;
    trig_prev_d = trig_now;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if ((state_q == LIVE) && edge_det) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      blank_cnt_q <= '0;
      pmod_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      blank_cnt_q <= blank_cnt_d;
      pmod_q      <= pmod_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      trig_prev_q <= trig_prev_d;
    end
  end

  assign pmod_o         = pmod_q;
  assign sel_active_o   = sel_q;
  assign blanking_o     = (state_q == BLANK);
  assign edge_cnt_o     = cnt_q;
  assign edge_cnt_ovf_o = ovf_q;

endmodule

// File: tb/tb_probe_mux_scope.sv
// tb/tb_probe_mux_scope.sv - self-checking bench for probe_mux_scope
module tb_probe_mux_scope;

  localparam int NG   = 4;
  localparam int PW   = 8;
  localparam int SS   = 2;
  localparam int BC   = 4;
  localparam int CW   = 4;
  localparam int SC   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NG*PW-1:0]  probes = '0;
  logic [1:0]        sel = '0;
  logic              en = 1'b0;
  logic              frz = 1'b0;
  logic [2:0]        trig = '0;
  logic              clr = 1'b0;
  logic [PW-1:0]     pmod_o;
  logic [1:0]        sel_active_o;
  logic              blanking_o;
  logic [CW-1:0]     edge_cnt_o;
  logic              edge_cnt_ovf_o;

  int checks = 0;
  int failures = 0;

  probe_mux_scope #(
    .NUM_GROUPS(NG), .PROBE_W(PW), .SYNC_STAGES(SS),
    .BLANK_CYCLES(BC), .CNT_W(CW), .STRETCH_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .probes_i(probes), .sel_i(sel),
    .enable_i(en), .freeze_i(frz), .trig_bit_i(trig), .cnt_clr_i(clr),
    .pmod_o(pmod_o), .sel_active_o(sel_active_o), .blanking_o(blanking_o),
    .edge_cnt_o(edge_cnt_o), .edge_cnt_ovf_o(edge_cnt_ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: probe history queue plus a mode/countdown view of the header.
  logic [NG*PW-1:0] m_hist [SS];
  int               m_mode;   // 0 off, 1 blanking, 2 live, 3 frozen
  int               m_sel, m_left, m_cnt;
  bit               m_ovf, m_prev;
  logic [PW-1:0]    m_pmod;
  int               m_str [PW];
  logic [PW-1:0]    m_sprev;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    for (int b = 0; b < PW; b++) m_str[b] = 0;
    m_mode = 0; m_sel = 0; m_left = 0; m_cnt = 0;
    m_ovf = 0; m_prev = 0; m_pmod = '0; m_sprev = '0;
  endtask

  task automatic model_step();
    logic [NG*PW-1:0] syn;
    logic [PW-1:0]    grp, hdr;
    bit               tn;
    int               nmode;
    syn = m_hist[SS-1];
    grp = (m_sel < NG) ? syn[m_sel*PW +: PW] : '0;
    hdr = grp;
`ifdef PROBE_STRETCH_EN
    for (int b = 0; b < PW; b++) begin
      if (m_str[b] != 0) hdr[b] = 1'b1;
      if (m_mode != 2) m_str[b] = 0;
      else if (grp[b] && !m_sprev[b]) m_str[b] = SC - 1;
      else if (m_str[b] > 0) m_str[b] = m_str[b] - 1;
    end
    m_sprev = grp;
`endif
    tn = grp[trig];
    if (clr) begin
      m_cnt = 0; m_ovf = 0;
    end else if (m_mode == 2 && tn && !m_prev) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt == CMAX) m_ovf = 1;
    end
    m_prev = tn;
    nmode = m_mode;
    if (!en) nmode = 0;
    else begin
      case (m_mode)
        0: begin nmode = 1; m_sel = int'(sel); m_left = BC - 1; end
        1: begin
          if (int'(sel) != m_sel) begin m_sel = int'(sel); m_left = BC - 1; end
          else if (m_left == 0) nmode = 2;
          else m_left--;
        end
        2: begin
          if (int'(sel) != m_sel) begin nmode = 1; m_sel = int'(sel); m_left = BC - 1; end
          else if (frz) nmode = 3;
        end
        default: begin
          if (!frz) begin
            if (int'(sel) != m_sel) begin nmode = 1; m_sel = int'(sel); m_left = BC - 1; end
            else nmode = 2;
          end
        end
      endcase
    end
    if (nmode == 2) m_pmod = hdr;
    else if (nmode != 3) m_pmod = '0;
    m_mode = nmode;
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = probes;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [63:0] act, exp;
    act = {pmod_o, sel_active_o, blanking_o, edge_cnt_o, edge_cnt_ovf_o};
    exp = {m_pmod, 2'(m_sel), (m_mode == 1), CW'(m_cnt), m_ovf};
    chk(name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 0; frz = 0; clr = 0; sel = '0; trig = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [1:0] sel;
    bit         frz;
    logic [7:0] g2;
    logic [7:0] e_pmod;
    bit         e_blank;
    logic [1:0] e_sel;
  } vec_t;

  vec_t tbl [14];
  int   highs;

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 8'hA5, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 8'hA5, 8'h00, 1'b1, 2'd2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hA5, 8'h00, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 8'hA5, 8'h00, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 8'hA5, 8'h00, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 8'hA5, 8'hA5, 1'b0, 2'd2};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 8'h5A, 8'hA5, 1'b0, 2'd2};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'h5A, 8'hA5, 1'b0, 2'd2};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 8'h5A, 8'h5A, 1'b0, 2'd2};
    tbl[9]  = '{1'b1, 2'd2, 1'b1, 8'hC3, 8'h5A, 1'b0, 2'd2};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 8'h0F, 8'h5A, 1'b0, 2'd2};
    tbl[11] = '{1'b1, 2'd2, 1'b1, 8'h0F, 8'h5A, 1'b0, 2'd2};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 8'h0F, 8'h0F, 1'b0, 2'd2};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 8'h0F, 8'h00, 1'b0, 2'd2};

    // Select, blank, live latency, freeze and disable via table
    probes = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    do_reset();
    chk("reset_pmod", pmod_o, 0);
    chk("reset_cnt", {edge_cnt_o, edge_cnt_ovf_o, blanking_o, sel_active_o}, 0);
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; sel = tbl[i].sel; frz = tbl[i].frz;
      probes[2*PW +: PW] = tbl[i].g2;
      tick();
      chk($sformatf("tbl%0d_pmod", i), pmod_o, tbl[i].e_pmod);
      chk($sformatf("tbl%0d_blank", i), blanking_o, tbl[i].e_blank);
      chk($sformatf("tbl%0d_sel", i), sel_active_o, tbl[i].e_sel);
    end

    // Reset asserted mid-LIVE with all-ones probes
    probes = '1; en = 1; sel = 2'd0;
    repeat (6) tick();
    chk("live_ones", pmod_o, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", {pmod_o, blanking_o, edge_cnt_o, edge_cnt_ovf_o, sel_active_o}, 0);
    model_reset();
    en = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {pmod_o, blanking_o, sel_active_o}, 0);
    en = 1; sel = 2'd1;
    tick();
    chk("idle_to_blank", {blanking_o, sel_active_o}, {1'b1, 2'd1});

    // Reselect during BLANK restarts the blank window
    probes = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    do_reset();
    en = 1; sel = 2'd1;
    repeat (6) tick();
    chk("g1_live", pmod_o, 8'h5A);
    sel = 2'd3; tick();
    chk("resel_blank", {pmod_o, blanking_o, sel_active_o}, {8'h00, 1'b1, 2'd3});
    tick();
    sel = 2'd1; tick();
    chk("back_blank", {pmod_o, blanking_o, sel_active_o}, {8'h00, 1'b1, 2'd1});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reblank%0d", i), {pmod_o, blanking_o}, {8'h00, 1'b1});
    end
    tick();
    chk("reblank_live", {pmod_o, blanking_o}, {8'h5A, 1'b0});
    chk_model("reblank_model");

    // Edge counter saturation and clear beating a coincident edge
    probes = '0;
    do_reset();
    en = 1; sel = 2'd0; trig = 3'd3;
    repeat (6) tick();
    for (int i = 0; i < 20; i++) begin
      probes[3] = 1'b1; tick(); tick();
      probes[3] = 1'b0; tick(); tick();
      if (i == 9) chk("cnt_10", {edge_cnt_o, edge_cnt_ovf_o}, {4'd10, 1'b0});
    end
    repeat (4) tick();
    chk("cnt_sat", {edge_cnt_o, edge_cnt_ovf_o}, {4'd15, 1'b1});
    probes[3] = 1'b1; tick(); tick();
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_edge", {edge_cnt_o, edge_cnt_ovf_o}, {4'd0, 1'b0});
    tick();
    chk("clr_hold", {edge_cnt_o, edge_cnt_ovf_o}, {4'd0, 1'b0});
    chk_model("cnt_model");

    // Single-cycle probe pulse width on the header
    probes = '0;
    do_reset();
    en = 1; sel = 2'd0;
    repeat (6) tick();
    probes[0] = 1'b1; tick();
    probes[0] = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pmod_o[0]) highs++;
    end
`ifdef PROBE_STRETCH_EN
    chk("pulse_width", highs, SC);
`else
    chk("pulse_width", highs, 1);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) frz = ~frz;
      if ($urandom_range(0, 49) == 0) trig = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 0) probes = {$urandom()};
      tick();
      chk_model($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
